// File: rtl/multi_bincount_pkg.sv
// Shared constants and channel-state type for the multi-channel rate divider.
package multi_bincount_pkg;

    localparam int unsigned WIDTH_DEF   = 14;
    localparam int unsigned DIV_RST_DEF = 12500;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] cnt;
        logic [WIDTH_DEF-1:0] act_div;
        logic [WIDTH_DEF-1:0] shd_div;
        logic                 pend;
    } ch_state_t;

endpackage : multi_bincount_pkg

// File: rtl/bincount_ch.sv
// One divider channel: counter, double-buffered divisor and boundary logic.
module bincount_ch
    import multi_bincount_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DIV_RST = DIV_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_div,
    output logic             out,
    output logic             pend
);

    localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_RST);
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             zero_s, term_s, bnd_s;

    // Boundary detection and next-state for counter, divisors and flags.
    always_comb begin
        zero_s = (act_q == ZERO_W);
        // zero divisor is excluded first so act_q-1 never wraps into a compare
        term_s = en && !zero_s && (cnt_q == (act_q - ONE_W));
        bnd_s  = sync || term_s || zero_s;
        out_d  = term_s && !sync;
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        if (bnd_s) begin
            cnt_d  = ZERO_W;
            pend_d = 1'b0;
            if (ld) begin
                act_d = ld_div;
                shd_d = ld_div;
            end else begin
                act_d = shd_q;
            end
        end else begin
            if (en) begin
                cnt_d = cnt_q + ONE_W;
            end else begin
                cnt_d = cnt_q;
            end
            if (ld) begin
                shd_d  = ld_div;
                pend_d = 1'b1;
            end else begin
                shd_d  = shd_q;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= ZERO_W;
            act_q  <= DIV_RST_W;
            shd_q  <= DIV_RST_W;
            pend_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            out_q  <= out_d;
        end
    end

    assign out  = out_q;
    assign pend = pend_q;

endmodule : bincount_ch

// File: rtl/multi_bincount.sv
// Multi-channel rate divider: decodes divisor writes and replicates bincount_ch.
module multi_bincount
    import multi_bincount_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned NCH     = 4,
    parameter int unsigned DIV_RST = DIV_RST_DEF,
    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   pend
);

    logic [NCH-1:0] ld_s;

    // Full-width channel compare, so out-of-range indices select nothing.
    always_comb begin
        ld_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
                ld_s[i] = 1'b1;
            end else begin
                ld_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        bincount_ch #(
            .WIDTH   (WIDTH),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .en     (en[g]),
            .sync   (sync),
            .ld     (ld_s[g]),
            .ld_div (wr_div),
            .out    (out[g]),
            .pend   (pend[g])
        );
    end

endmodule : multi_bincount

// File: tb/tb_multi_bincount.sv
// Directed self-checking bench for multi_bincount (5 channels, so wr_ch can exceed NCH-1).
module tb_multi_bincount;

    localparam int NCH   = 5;
    localparam int WIDTH = 14;
    localparam int CH_W  = 3;

    logic             clk;
    logic             reset;
    logic [NCH-1:0]   en;
    logic             sync;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_div;
    logic [NCH-1:0]   out;
    logic [NCH-1:0]   pend;

    int n_checks = 0;
    int n_fail   = 0;

    multi_bincount #(.WIDTH(WIDTH), .NCH(NCH), .DIV_RST(12500)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .out    (out),
        .pend   (pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] div);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = div;
    endtask

    initial begin
        logic [NCH-1:0] prev;
        int pulses;
        int consec;
        int waited;

        reset  = 1'b0;
        en     = {NCH{1'b1}};
        sync   = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = 3'd0;
        wr_div = 14'd0;
        #20;
        check("rst_out", 32'(out), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        #2 reset = 1'b1;

        // Default divisor: pulses after edges 12500, 25000, 37500 only
        prev   = '0;
        pulses = 0;
        consec = 0;
        for (int e = 1; e <= 37502; e++) begin
            tick();
            for (int b = 0; b < NCH; b++) begin
                if (out[b]) pulses++;
                if (out[b] && prev[b]) consec++;
            end
            prev = out;
            if (e == 12499) check("def_12499", 32'(out), 32'd0);
            if (e == 12500) check("def_12500", 32'(out), 32'h1F);
            if (e == 12501) check("def_12501", 32'(out), 32'd0);
            if (e == 25000) check("def_25000", 32'(out), 32'h1F);
            if (e == 37500) check("def_37500", 32'(out), 32'h1F);
        end
        check("def_pulses", 32'(pulses), 32'd15);
        check("def_consec", 32'(consec), 32'd0);

        // ch1 := 5 with sync, then write 3 mid-period
        set_wr(3'd1, 14'd5); sync = 1'b1;
        tick(); wr_en = 1'b0; sync = 1'b0;
        check("s_pend", 32'(pend), 32'd0);
        tick(); tick();
        set_wr(3'd1, 14'd3);
        tick(); wr_en = 1'b0;
        check("mid_pend3", 32'(pend), 32'h02);
        check("mid_out3", 32'(out), 32'd0);
        tick();
        check("mid_pend4", 32'(pend), 32'h02);
        check("mid_out4", 32'(out), 32'd0);
        tick();
        check("mid_out5", 32'(out), 32'h02);
        check("mid_pend5", 32'(pend), 32'd0);
        tick(); check("mid_out6", 32'(out), 32'd0);
        tick(); check("mid_out7", 32'(out), 32'd0);
        tick(); check("mid_out8", 32'(out), 32'h02);
        tick(); tick();
        tick(); check("mid_out11", 32'(out), 32'h02);

        // ch0=4 via sync, ch2=6 and ch3=5 pending, sync at A+4
        set_wr(3'd0, 14'd4); sync = 1'b1;
        tick(); wr_en = 1'b0; sync = 1'b0;
        set_wr(3'd2, 14'd6); tick();
        set_wr(3'd3, 14'd5); tick(); wr_en = 1'b0;
        tick();
        check("sy_pend3", 32'(pend), 32'h0C);
        check("sy_out3", 32'(out), 32'h02);
        sync = 1'b1; tick(); sync = 1'b0;
        check("sy_out4", 32'(out), 32'd0);
        check("sy_pend4", 32'(pend), 32'd0);
        tick(); check("sy_out5", 32'(out), 32'd0);
        tick(); check("sy_out6", 32'(out), 32'd0);
        tick(); check("sy_out7", 32'(out), 32'h02);
        tick(); check("sy_out8", 32'(out), 32'h01);
        tick(); check("sy_out9", 32'(out), 32'h08);
        tick(); check("sy_out10", 32'(out), 32'h06);

        // ch3 := 0 (stopped), then 2 applied on the next edge
        set_wr(3'd3, 14'd0); sync = 1'b1;
        tick(); wr_en = 1'b0; sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("z_out3", 32'(out[3]), 32'd0);
        end
        set_wr(3'd3, 14'd2); tick(); wr_en = 1'b0;
        check("z_pend3", 32'(pend[3]), 32'd0);
        check("z_outC", 32'(out[3]), 32'd0);
        tick(); check("z_outC1", 32'(out[3]), 32'd0);
        tick(); check("z_outC2", 32'(out[3]), 32'd1);
        tick(); check("z_outC3", 32'(out[3]), 32'd0);
        tick(); check("z_outC4", 32'(out[3]), 32'd1);

        // ch0 := 10, 4 counts, 7 disabled clocks, then 6 more counts
        set_wr(3'd0, 14'd10); sync = 1'b1;
        tick(); wr_en = 1'b0; sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("en_run", 32'(out[0]), 32'd0);
        end
        en[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(); check("en_off", 32'(out[0]), 32'd0);
        end
        en[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); check("en_resume", 32'(out[0]), 32'd0);
        end
        tick(); check("en_pulse", 32'(out[0]), 32'd1);

        // Pending write on ch1, then async reset while out[3] is high
        en = 5'b01000;
        set_wr(3'd1, 14'd7); tick(); wr_en = 1'b0;
        check("r_pend", 32'(pend), 32'h02);
        waited = 0;
        while (!out[3] && waited < 4) begin
            tick();
            waited++;
        end
        check("r_out3_seen", 32'(out[3]), 32'd1);
        reset = 1'b0;
        #1;
        check("r_async_out", 32'(out), 32'd0);
        check("r_async_pend", 32'(pend), 32'd0);
        #2 reset = 1'b1;
        en = {NCH{1'b1}};
        set_wr(3'd5, 14'd3); tick(); wr_en = 1'b0;
        check("r_oob_pend", 32'(pend), 32'd0);
        set_wr(3'd7, 14'd3); tick(); wr_en = 1'b0;
        check("r_oob7_pend", 32'(pend), 32'd0);
        for (int e = 3; e <= 12500; e++) begin
            tick();
            if (e == 12499) check("r_12499", 32'(out), 32'd0);
            if (e == 12500) check("r_12500", 32'(out), 32'h1F);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multi_bincount
